// File: rtl/store_buffer.sv
// Store buffer: FIFO of pending stores draining to data memory,
// with combinational store-to-load forwarding and conflict stall.
module store_buffer #(
  parameter int DEPTH = 4
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        St_valid,
  output logic        St_ready,
  input  logic [15:0] St_Ad,
  input  logic [31:0] St_Data,
  input  logic [1:0]  St_Size,
  input  logic        Ld_valid,
  input  logic [15:0] Ld_Ad,
  input  logic [1:0]  Ld_Size,
  output logic        Ld_hit,
  output logic [31:0] Ld_Data,
  output logic        Ld_stall,
  input  logic        Mem_busy,
  output logic [15:0] Mem_Ad,
  output logic [31:0] Mem_WrData,
  output logic [2:0]  Mem_Wr,
  output logic [3:0]  Count,
  output logic        Empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] DEPTH_C = 4'(DEPTH);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  logic [15:0]      ad_q   [DEPTH];
  logic [31:0]      data_q [DEPTH];
  logic [1:0]       size_q [DEPTH];
  logic [DEPTH-1:0] vld_q, vld_d;
  logic [PW-1:0]    head_q, head_d;
  logic [PW-1:0]    tail_q, tail_d;
  logic [3:0]       cnt_q, cnt_d;

  logic push, pop;

  logic        y_found;
  logic        y_word;
  logic        y_exact;
  logic [31:0] y_data;
  logic [PW-1:0] idx;
  logic [15:0] dfw, dbw;

  assign Count    = cnt_q;
  assign Empty    = (cnt_q == 4'd0);
  assign St_ready = (cnt_q < DEPTH_C);
  assign push     = St_valid && St_ready;
  assign pop      = (Mem_Wr != 3'd0);

  // Drain port: head entry presented to memory when the port is free
  always_comb begin
    Mem_Ad     = ad_q[head_q];
    Mem_WrData = data_q[head_q];
    Mem_Wr     = 3'd0;
    if (!Empty && !Mem_busy) begin
      case (size_q[head_q])
        2'd1:    Mem_Wr = 3'd2;
        2'd2:    Mem_Wr = 3'd4;
        default: Mem_Wr = 3'd1;
      endcase
    end
  end

  // Pointer, valid and occupancy next-state
  always_comb begin
    vld_d  = vld_q;
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    if (pop) begin
      vld_d[head_q] = 1'b0;
      head_d = (head_q == LAST) ? '0 : head_q + 1'b1;
    end
    if (push) begin
      vld_d[tail_q] = 1'b1;
      tail_d = (tail_q == LAST) ? '0 : tail_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 4'd1;
      2'b01:   cnt_d = cnt_q - 4'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Control state, cleared immediately on reset
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      vld_q  <= '0;
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
    end else begin
      vld_q  <= vld_d;
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
    end
  end

  // Entry payload, written at the tail on push; no reset needed
  always_ff @(posedge Clk) begin
    if (push) begin
      ad_q[tail_q]   <= St_Ad;
      data_q[tail_q] <= St_Data;
      size_q[tail_q] <= St_Size;
    end
  end

  // Walk entries oldest to youngest; last overlapping one wins
  always_comb begin
    y_found = 1'b0;
    y_word  = 1'b0;
    y_exact = 1'b0;
    y_data  = '0;
    idx     = '0;
    dfw     = '0;
    dbw     = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = (32'(head_q) + 32'(k) >= 32'(DEPTH))
          ? PW'(32'(head_q) + 32'(k) - 32'(DEPTH))
          : PW'(32'(head_q) + 32'(k));
      dfw = ad_q[idx] - Ld_Ad;
      dbw = Ld_Ad - ad_q[idx];
      if (vld_q[idx] &&
          ((dfw < 16'd4) || (dbw >= 16'd1 && dbw <= 16'd3))) begin
        y_found = 1'b1;
        y_word  = (size_q[idx] == 2'd0) || (size_q[idx] == 2'd3);
        y_exact = (ad_q[idx] == Ld_Ad);
        y_data  = data_q[idx];
      end
    end
  end

  // Forwarding result: exact word match hits, other overlaps stall
  always_comb begin
    Ld_hit   = 1'b0;
    Ld_stall = 1'b0;
    Ld_Data  = '0;
    if (Ld_valid && y_found) begin
      if (y_word && y_exact) begin
        Ld_hit = 1'b1;
        case (Ld_Size)
          2'd1:    Ld_Data = {24'd0, y_data[7:0]};
          2'd2:    Ld_Data = {16'd0, y_data[15:0]};
          default: Ld_Data = y_data;
        endcase
      end else begin
        Ld_stall = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer (DEPTH 4): drain, fill/hold,
// back-to-back, forwarding, stall, youngest-wins and mid-run reset.
module tb_store_buffer;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        St_valid;
  logic        St_ready;
  logic [15:0] St_Ad;
  logic [31:0] St_Data;
  logic [1:0]  St_Size;
  logic        Ld_valid;
  logic [15:0] Ld_Ad;
  logic [1:0]  Ld_Size;
  logic        Ld_hit;
  logic [31:0] Ld_Data;
  logic        Ld_stall;
  logic        Mem_busy;
  logic [15:0] Mem_Ad;
  logic [31:0] Mem_WrData;
  logic [2:0]  Mem_Wr;
  logic [3:0]  Count;
  logic        Empty;

  int nt = 0;
  int nf = 0;

  logic [15:0] f_ad   [5] = '{16'h0100, 16'h0104, 16'h0108, 16'h010C, 16'h0110};
  logic [31:0] f_dat  [5] = '{32'h11111111, 32'h00000022, 32'h00003333,
                             32'h44444444, 32'h55555555};
  logic [1:0]  f_sz   [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
  logic [2:0]  f_code [5] = '{3'd1, 3'd2, 3'd4, 3'd1, 3'd1};

  logic [15:0] l_ad  [9] = '{16'hFF20, 16'hFF20, 16'hFF20, 16'hFF20, 16'hFF22,
                            16'hFF23, 16'hFF24, 16'hFF1D, 16'hFF1C};
  logic [1:0]  l_sz  [9] = '{2'd1, 2'd2, 2'd0, 2'd3, 2'd0, 2'd1, 2'd0, 2'd0, 2'd0};
  logic        l_hit [9] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  logic        l_stl [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
  logic [31:0] l_dat [9] = '{32'h000000DD, 32'h0000CCDD, 32'hAABBCCDD, 32'hAABBCCDD,
                            32'h0, 32'h0, 32'h0, 32'h0, 32'h0};

  always #5 Clk = ~Clk;

  store_buffer #(.DEPTH(4)) dut (
    .Clk(Clk), .Reset(Reset),
    .St_valid(St_valid), .St_ready(St_ready),
    .St_Ad(St_Ad), .St_Data(St_Data), .St_Size(St_Size),
    .Ld_valid(Ld_valid), .Ld_Ad(Ld_Ad), .Ld_Size(Ld_Size),
    .Ld_hit(Ld_hit), .Ld_Data(Ld_Data), .Ld_stall(Ld_stall),
    .Mem_busy(Mem_busy), .Mem_Ad(Mem_Ad), .Mem_WrData(Mem_WrData),
    .Mem_Wr(Mem_Wr), .Count(Count), .Empty(Empty)
  );

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset;
    Reset = 1'b0; St_valid = 0; St_Ad = 0; St_Data = 0; St_Size = 0;
    Ld_valid = 0; Ld_Ad = 0; Ld_Size = 0; Mem_busy = 0;
    #2;
    nt++; if (Count !== 4'd0) begin nf++; $display("FAIL rst_count got %0d want 0", Count); end
    nt++; if (Empty !== 1'b1) begin nf++; $display("FAIL rst_empty got %b want 1", Empty); end
    nt++; if (St_ready !== 1'b1) begin nf++; $display("FAIL rst_ready got %b want 1", St_ready); end
    nt++; if (Mem_Wr !== 3'd0) begin nf++; $display("FAIL rst_memwr got %0d want 0", Mem_Wr); end
    nt++; if (Ld_hit !== 1'b0 || Ld_stall !== 1'b0) begin
      nf++; $display("FAIL rst_ld hit %b stall %b want 0 0", Ld_hit, Ld_stall); end
    tick;
    Reset = 1'b1;
    tick;
  endtask

  task automatic test_single;
    Mem_busy = 0;
    St_valid = 1; St_Ad = 16'hFF10; St_Data = 32'h12345678; St_Size = 0;
    #1;
    nt++; if (Mem_Wr !== 3'd0) begin nf++; $display("FAIL single_pre got %0d want 0", Mem_Wr); end
    tick;
    St_valid = 0;
    #1;
    nt++; if (Mem_Wr !== 3'd1) begin nf++; $display("FAIL single_wr got %0d want 1", Mem_Wr); end
    nt++; if (Mem_Ad !== 16'hFF10) begin nf++; $display("FAIL single_ad got %h want ff10", Mem_Ad); end
    nt++; if (Mem_WrData !== 32'h12345678) begin
      nf++; $display("FAIL single_data got %h want 12345678", Mem_WrData); end
    nt++; if (Count !== 4'd1) begin nf++; $display("FAIL single_cnt got %0d want 1", Count); end
    tick;
    nt++; if (Empty !== 1'b1) begin nf++; $display("FAIL single_empty got %b want 1", Empty); end
    nt++; if (Mem_Wr !== 3'd0) begin nf++; $display("FAIL single_post got %0d want 0", Mem_Wr); end
  endtask

  task automatic test_fill;
    Mem_busy = 1;
    for (int i = 0; i < 4; i++) begin
      St_valid = 1; St_Ad = f_ad[i]; St_Data = f_dat[i]; St_Size = f_sz[i];
      tick;
    end
    St_Ad = f_ad[4]; St_Data = f_dat[4]; St_Size = f_sz[4];
    #1;
    nt++; if (Count !== 4'd4) begin nf++; $display("FAIL fill_cnt got %0d want 4", Count); end
    nt++; if (St_ready !== 1'b0) begin nf++; $display("FAIL fill_ready got %b want 0", St_ready); end
    nt++; if (Mem_Wr !== 3'd0) begin nf++; $display("FAIL fill_busy got %0d want 0", Mem_Wr); end
    tick;
    nt++; if (Count !== 4'd4) begin nf++; $display("FAIL fill_held got %0d want 4", Count); end
    Mem_busy = 0;
    #1;
    nt++; if (St_ready !== 1'b0) begin nf++; $display("FAIL fill_nopass got %b want 0", St_ready); end
    nt++; if (Mem_Wr !== f_code[0] || Mem_Ad !== f_ad[0]) begin
      nf++; $display("FAIL drain0 wr %0d ad %h want %0d %h", Mem_Wr, Mem_Ad, f_code[0], f_ad[0]); end
    tick;
    nt++; if (Count !== 4'd3) begin nf++; $display("FAIL drain0_cnt got %0d want 3", Count); end
    for (int i = 1; i < 5; i++) begin
      #1;
      nt++; if (Mem_Wr !== f_code[i] || Mem_Ad !== f_ad[i] || Mem_WrData !== f_dat[i]) begin
        nf++; $display("FAIL drain%0d wr %0d ad %h d %h want %0d %h %h",
                       i, Mem_Wr, Mem_Ad, Mem_WrData, f_code[i], f_ad[i], f_dat[i]); end
      tick;
      if (i == 1) begin
        St_valid = 0;
        nt++; if (Count !== 4'd3) begin nf++; $display("FAIL pushpop_cnt got %0d want 3", Count); end
      end
    end
    nt++; if (Empty !== 1'b1) begin nf++; $display("FAIL fill_empty got %b want 1", Empty); end
  endtask

  task automatic test_back_to_back;
    Mem_busy = 0;
    for (int i = 0; i < 6; i++) begin
      St_valid = 1; St_Ad = 16'h0200 + 16'(4 * i); St_Data = 32'hA0 + 32'(i); St_Size = 0;
      tick;
      nt++; if (Count !== 4'd1 || Mem_Ad !== 16'h0200 + 16'(4 * i)) begin
        nf++; $display("FAIL b2b%0d cnt %0d ad %h want 1 %h", i, Count, Mem_Ad, 16'h0200 + 16'(4 * i)); end
    end
    St_valid = 0;
    tick;
    nt++; if (Empty !== 1'b1) begin nf++; $display("FAIL b2b_empty got %b want 1", Empty); end
  endtask

  task automatic test_forward;
    Mem_busy = 1;
    St_valid = 1; St_Ad = 16'hFF20; St_Data = 32'hAABBCCDD; St_Size = 0;
    tick;
    St_valid = 0;
    Ld_valid = 1;
    for (int i = 0; i < 9; i++) begin
      Ld_Ad = l_ad[i]; Ld_Size = l_sz[i];
      #1;
      nt++; if (Ld_hit !== l_hit[i] || Ld_stall !== l_stl[i] || Ld_Data !== l_dat[i]) begin
        nf++; $display("FAIL fwd%0d hit %b stall %b d %h want %b %b %h",
                       i, Ld_hit, Ld_stall, Ld_Data, l_hit[i], l_stl[i], l_dat[i]); end
    end
    Ld_valid = 0; Ld_Ad = 16'hFF20; Ld_Size = 0;
    #1;
    nt++; if (Ld_hit !== 1'b0 || Ld_stall !== 1'b0 || Ld_Data !== 32'd0) begin
      nf++; $display("FAIL fwd_novalid hit %b stall %b d %h want 0 0 0", Ld_hit, Ld_stall, Ld_Data); end
    Mem_busy = 0;
    tick;
    nt++; if (Empty !== 1'b1) begin nf++; $display("FAIL fwd_empty got %b want 1", Empty); end
  endtask

  task automatic test_partial;
    Mem_busy = 1;
    St_valid = 1; St_Ad = 16'hFF21; St_Data = 32'h000000EE; St_Size = 1;
    tick;
    St_valid = 0;
    Ld_valid = 1; Ld_Ad = 16'hFF20; Ld_Size = 0;
    #1;
    nt++; if (Ld_stall !== 1'b1 || Ld_hit !== 1'b0) begin
      nf++; $display("FAIL part_stall stall %b hit %b want 1 0", Ld_stall, Ld_hit); end
    Mem_busy = 0;
    #1;
    nt++; if (Ld_stall !== 1'b1 || Mem_Wr !== 3'd2) begin
      nf++; $display("FAIL part_draining stall %b wr %0d want 1 2", Ld_stall, Mem_Wr); end
    tick;
    nt++; if (Ld_stall !== 1'b0 || Ld_hit !== 1'b0 || Empty !== 1'b1) begin
      nf++; $display("FAIL part_after stall %b hit %b empty %b want 0 0 1", Ld_stall, Ld_hit, Empty); end
    Ld_valid = 0;
  endtask

  task automatic test_youngest;
    int c;
    Mem_busy = 1;
    St_valid = 1; St_Ad = 16'hFF30; St_Data = 32'h1; St_Size = 0;
    tick;
    St_Data = 32'h2;
    tick;
    St_valid = 0;
    Ld_valid = 1; Ld_Ad = 16'hFF30; Ld_Size = 0;
    #1;
    nt++; if (Ld_hit !== 1'b1 || Ld_Data !== 32'h2) begin
      nf++; $display("FAIL young hit %b d %h want 1 2", Ld_hit, Ld_Data); end
    St_valid = 1; St_Ad = 16'hFF40; St_Data = 32'h40; St_Size = 0;
    Ld_Ad = 16'hFF40;
    #1;
    nt++; if (Ld_hit !== 1'b0 || Ld_stall !== 1'b0) begin
      nf++; $display("FAIL samecyc hit %b stall %b want 0 0", Ld_hit, Ld_stall); end
    tick;
    St_valid = 0;
    #1;
    nt++; if (Ld_hit !== 1'b1 || Ld_Data !== 32'h40) begin
      nf++; $display("FAIL nextcyc hit %b d %h want 1 40", Ld_hit, Ld_Data); end
    Ld_valid = 0;
    Mem_busy = 0;
    c = 0;
    while (!Empty && c < 10) begin
      tick;
      c++;
    end
    nt++; if (Empty !== 1'b1 || c != 3) begin
      nf++; $display("FAIL young_drain empty %b cycles %0d want 1 3", Empty, c); end
  endtask

  task automatic test_reset_mid;
    Mem_busy = 1;
    for (int i = 0; i < 3; i++) begin
      St_valid = 1; St_Ad = 16'h0300 + 16'(4 * i); St_Data = 32'h300 + 32'(i); St_Size = 0;
      tick;
    end
    St_valid = 0;
    #1;
    nt++; if (Count !== 4'd3) begin nf++; $display("FAIL mid_cnt got %0d want 3", Count); end
    Mem_busy = 0;
    #1;
    nt++; if (Mem_Wr !== 3'd1) begin nf++; $display("FAIL mid_wr got %0d want 1", Mem_Wr); end
    Reset = 0;
    #1;
    nt++; if (Mem_Wr !== 3'd0 || Count !== 4'd0 || Empty !== 1'b1 || St_ready !== 1'b1) begin
      nf++; $display("FAIL mid_rst wr %0d cnt %0d empty %b rdy %b want 0 0 1 1",
                     Mem_Wr, Count, Empty, St_ready); end
    tick;
    Reset = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      nt++; if (Mem_Wr !== 3'd0) begin nf++; $display("FAIL mid_after%0d wr %0d want 0", i, Mem_Wr); end
      tick;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset;
    test_single;
    test_fill;
    test_back_to_back;
    test_forward;
    test_partial;
    test_youngest;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", nt, nf);
    $finish;
  end

endmodule
